// File: rtl/fip_32_cramer_solve.sv
// Cramer-rule solver for ray/triangle hits: t,u,v = det_{t,u,v}/det through one shared restoring divider.
// Define FIP_DIV_SAT_EN to clamp quotients to the 32-bit signed range instead of wrapping.
module fip_32_cramer_solve #(
  parameter int                 FRA_BITS = 16,
  parameter logic signed [31:0] EPS      = 32'sh10,
  parameter logic signed [31:0] T_MIN    = 32'sh0
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic signed [31:0] i_det,
  input  logic signed [31:0] i_det_t,
  input  logic signed [31:0] i_det_u,
  input  logic signed [31:0] i_det_v,
  output logic               o_valid,
  input  logic               i_ready,
  output logic signed [31:0] o_t,
  output logic signed [31:0] o_u,
  output logic signed [31:0] o_v,
  output logic               o_hit
);

  localparam int DW   = 32 + FRA_BITS;
  localparam int ITER = DW;
  localparam int CW   = $clog2(ITER);
  localparam logic signed [32:0] ONE_FX = 33'sd1 <<< FRA_BITS;

  typedef enum logic [2:0] {IDLE, DIV_U, DIV_V, DIV_T, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 o_valid_q, o_valid_d;
  logic signed [31:0]   o_t_q, o_t_d, o_u_q, o_u_d, o_v_q, o_v_d;
  logic                 o_hit_q, o_hit_d;
  logic [32:0]          dsr_q, dsr_d;
  logic                 det_neg_q, det_neg_d;
  logic signed [31:0]   nt_q, nt_d, nv_q, nv_d;
  logic [31:0]          rem_q, rem_d;
  logic [DW-1:0]        dvd_q, dvd_d;
  logic                 neg_q, neg_d;
  logic signed [31:0]   u_q, u_d, v_q, v_d;

  function automatic logic [32:0] abs33(input logic signed [31:0] x);
    logic signed [32:0] e;
    e = {x[31], x};
    return x[31] ? 33'(-e) : 33'(e);
  endfunction

  // Signed result from magnitude and sign: clamp or keep the low 32 bits.
  function automatic logic signed [31:0] finish_q(input logic [DW-1:0] mag, input logic neg);
    logic [DW-1:0] s;
`ifdef FIP_DIV_SAT_EN
    if (!neg && mag > DW'(64'h7fff_ffff)) return 32'sh7fffffff;
    if (neg && mag > DW'(64'h8000_0000)) return 32'sh80000000;
`endif
    s = neg ? -mag : mag;
    return s[31:0];
  endfunction

  function automatic logic hit_f(input logic signed [31:0] t, input logic signed [31:0] u,
                                 input logic signed [31:0] v);
    logic signed [32:0] uv;
    uv = {u[31], u} + {v[31], v};
    return !u[31] && !v[31] && (uv <= ONE_FX) && (t >= T_MIN);
  endfunction

  // Operand to load into the divider for the next quotient (u, then v, then t).
  logic signed [31:0] ld_num;
  logic               ld_dneg;
  logic [32:0]        ld_abs, det_abs;
  logic [DW-1:0]      ld_dvd;
  logic               ld_neg;

  always_comb begin
    ld_num  = nt_q;
    ld_dneg = det_neg_q;
    if (state_q == IDLE) begin
      ld_num  = i_det_u;
      ld_dneg = i_det[31];
    end else if (state_q == DIV_U) begin
      ld_num  = nv_q;
    end
  end

  assign ld_abs  = abs33(ld_num);
  assign det_abs = abs33(i_det);
  assign ld_dvd  = {ld_abs[31:0], {FRA_BITS{1'b0}}};
  assign ld_neg  = ld_num[31] ^ ld_dneg;

  // One restoring step: dividend MSB shifts into the remainder, quotient bit into the LSB.
  logic [32:0]        trial, diff;
  logic               ge;
  logic [31:0]        rem_step;
  logic [DW-1:0]      q_step;
  logic signed [31:0] res;

  assign trial    = {rem_q, dvd_q[DW-1]};
  assign diff     = trial - dsr_q;
  assign ge       = trial >= dsr_q;
  assign rem_step = ge ? diff[31:0] : trial[31:0];
  assign q_step   = {dvd_q[DW-2:0], ge};
  assign res      = finish_q(q_step, neg_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    o_valid_d = 1'b0;
    o_t_d     = o_t_q;
    o_u_d     = o_u_q;
    o_v_d     = o_v_q;
    o_hit_d   = o_hit_q;
    dsr_d     = dsr_q;
    det_neg_d = det_neg_q;
    nt_d      = nt_q;
    nv_d      = nv_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    neg_d     = neg_q;
    u_d       = u_q;
    v_d       = v_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          dsr_d     = det_abs;
          det_neg_d = i_det[31];
          nt_d      = i_det_t;
          nv_d      = i_det_v;
          if (det_abs <= {1'b0, EPS}) begin
            state_d = DONE;
            o_t_d   = '0;
            o_u_d   = '0;
            o_v_d   = '0;
            o_hit_d = 1'b0;
          end else begin
            state_d = DIV_U;
            cnt_d   = '0;
            rem_d   = '0;
            dvd_d   = ld_dvd;
            neg_d   = ld_neg;
          end
        end
      end
      DIV_U, DIV_V, DIV_T: begin
        rem_d = rem_step;
        dvd_d = q_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) begin
          cnt_d = '0;
          rem_d = '0;
          dvd_d = ld_dvd;
          neg_d = ld_neg;
          case (state_q)
            DIV_U: begin
              u_d     = res;
              state_d = DIV_V;
            end
            DIV_V: begin
              v_d     = res;
              state_d = DIV_T;
            end
            default: begin
              state_d = DONE;
              o_t_d   = res;
              o_u_d   = u_q;
              o_v_d   = v_q;
              o_hit_d = hit_f(res, u_q, v_q);
            end
          endcase
        end
      end
      DONE: begin
        if (o_valid_q && i_ready) begin
          state_d = IDLE;
        end else begin
          o_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      o_valid_q <= 1'b0;
      o_t_q     <= '0;
      o_u_q     <= '0;
      o_v_q     <= '0;
      o_hit_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      o_valid_q <= o_valid_d;
      o_t_q     <= o_t_d;
      o_u_q     <= o_u_d;
      o_v_q     <= o_v_d;
      o_hit_q   <= o_hit_d;
    end
  end

  // Operand and divider datapath: qualified by the FSM, so no reset needed.
  always_ff @(posedge i_clk) begin
    dsr_q     <= dsr_d;
    det_neg_q <= det_neg_d;
    nt_q      <= nt_d;
    nv_q      <= nv_d;
    rem_q     <= rem_d;
    dvd_q     <= dvd_d;
    neg_q     <= neg_d;
    u_q       <= u_d;
    v_q       <= v_d;
  end

  assign o_ready = (state_q == IDLE);
  assign o_valid = o_valid_q;
  assign o_t     = o_t_q;
  assign o_u     = o_u_q;
  assign o_v     = o_v_q;
  assign o_hit   = o_hit_q;

endmodule

// File: tb/tb_fip_32_cramer_solve.sv
// Randomized and directed bench for fip_32_cramer_solve against a 64-bit arithmetic reference model.
module tb_fip_32_cramer_solve;
  localparam int FRA = 16;
  localparam int LAT = 1 + 3 * (32 + FRA);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               i_rstn, i_valid, i_ready, o_ready, o_valid, o_hit;
  logic signed [31:0] i_det, i_det_t, i_det_u, i_det_v, o_t, o_u, o_v;

  int checks = 0;
  int passes = 0;

  fip_32_cramer_solve dut (
    .i_clk(clk), .i_rstn(i_rstn), .i_valid(i_valid), .o_ready(o_ready),
    .i_det(i_det), .i_det_t(i_det_t), .i_det_u(i_det_u), .i_det_v(i_det_v),
    .o_valid(o_valid), .i_ready(i_ready), .o_t(o_t), .o_u(o_u), .o_v(o_v), .o_hit(o_hit)
  );

  function automatic logic [31:0] q_model(input logic signed [31:0] n, input logic signed [31:0] d);
    longint signed   sn, sd;
    longint unsigned an, ad, mag;
    bit              neg;
    sn  = longint'(n);
    sd  = longint'(d);
    an  = (sn < 0) ? longint'(-sn) : sn;
    ad  = (sd < 0) ? longint'(-sd) : sd;
    mag = (an << FRA) / ad;
    neg = (sn < 0) != (sd < 0);
`ifdef FIP_DIV_SAT_EN
    if (!neg && mag > 64'h7fff_ffff) return 32'h7fff_ffff;
    if (neg && mag > 64'h8000_0000) return 32'h8000_0000;
`endif
    return neg ? 32'(-mag) : 32'(mag);
  endfunction

  function automatic void model(input logic signed [31:0] d, input logic signed [31:0] dt,
                                input logic signed [31:0] du, input logic signed [31:0] dv,
                                output int lat, output logic [31:0] t, output logic [31:0] u,
                                output logic [31:0] v, output logic hit);
    longint sd;
    sd = longint'(d);
    if (sd <= 16 && sd >= -16) begin
      lat = 1; t = 0; u = 0; v = 0; hit = 0;
    end else begin
      lat = LAT;
      t   = q_model(dt, d);
      u   = q_model(du, d);
      v   = q_model(dv, d);
      hit = (int'(u) >= 0) && (int'(v) >= 0) &&
            (longint'(int'(u)) + longint'(int'(v)) <= 65536) && (int'(t) >= 0);
    end
  endfunction

  task automatic send_wait(input logic [31:0] d, input logic [31:0] dt, input logic [31:0] du,
                           input logic [31:0] dv, output int lat);
    i_det = d; i_det_t = dt; i_det_u = du; i_det_v = dv;
    i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (o_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic handoff();
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_t !== 0 || o_u !== 0 || o_v !== 0 || o_hit !== 1'b0)
      $display("FAIL reset: got vld=%b rdy=%b t=%h u=%h v=%h hit=%b, want 0 1 0 0 0 0",
               o_valid, o_ready, o_t, o_u, o_v, o_hit);
    else passes++;
  endtask

  task automatic test_directed();
    logic [31:0] tab [7][4];
    int          lat, elat;
    logic [31:0] et, eu, ev;
    logic        eh;
    tab[0] = '{32'h0002_0000, 32'h0004_0000, 32'h0000_8000, 32'h0000_8000};
    tab[1] = '{32'hFFFF_0000, 32'hFFFE_0000, 32'hFFFF_C000, 32'h0000_0000};
    tab[2] = '{32'h0000_0010, 32'h1234_5678, 32'h0000_4000, 32'h0000_4000};
    tab[3] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_C000, 32'h0000_8000};
    tab[4] = '{32'h0000_0020, 32'h7FFF_0000, 32'h0000_0000, 32'h0000_0000};
    tab[5] = '{32'hFFFF_FFF0, 32'h0001_0000, 32'h0000_1000, 32'h0000_1000};
    tab[6] = '{32'h0000_0011, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF};
    for (int i = 0; i < 7; i++) begin
      send_wait(tab[i][0], tab[i][1], tab[i][2], tab[i][3], lat);
      model(tab[i][0], tab[i][1], tab[i][2], tab[i][3], elat, et, eu, ev, eh);
      checks++;
      if (lat !== elat) $display("FAIL directed[%0d] latency: got %0d want %0d", i, lat, elat);
      else passes++;
      checks++;
      if (o_t !== et || o_u !== eu || o_v !== ev)
        $display("FAIL directed[%0d] tuv: got %h %h %h want %h %h %h", i, o_t, o_u, o_v, et, eu, ev);
      else passes++;
      checks++;
      if (o_hit !== eh) $display("FAIL directed[%0d] hit: got %b want %b", i, o_hit, eh);
      else passes++;
      handoff();
    end
    // The spec's nominal vector, checked against literal values as well.
    send_wait(32'h0002_0000, 32'h0004_0000, 32'h0000_8000, 32'h0000_8000, lat);
    checks++;
    if (lat !== 145 || o_t !== 32'h0002_0000 || o_u !== 32'h4000 || o_v !== 32'h4000 || o_hit !== 1'b1)
      $display("FAIL nominal literal: got lat=%0d t=%h u=%h v=%h hit=%b want 145 20000 4000 4000 1",
               lat, o_t, o_u, o_v, o_hit);
    else passes++;
    handoff();
  endtask

  task automatic test_hold();
    int          lat;
    logic [31:0] st, su, sv;
    logic        sh;
    send_wait(32'h0001_0000, 32'h0003_0000, 32'h0000_2000, 32'h0000_6000, lat);
    st = o_t; su = o_u; sv = o_v; sh = o_hit;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_t !== st || o_u !== su || o_v !== sv || o_hit !== sh)
        $display("FAIL hold[%0d]: got vld=%b rdy=%b t=%h u=%h v=%h hit=%b want 1 0 %h %h %h %b",
                 c, o_valid, o_ready, o_t, o_u, o_v, o_hit, st, su, sv, sh);
      else passes++;
    end
    handoff();
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1)
      $display("FAIL handoff: got vld=%b rdy=%b want 0 1", o_valid, o_ready);
    else passes++;
  endtask

  task automatic test_reset_mid_div();
    int          lat, elat;
    logic [31:0] et, eu, ev;
    logic        eh;
    i_det = 32'h0002_0000; i_det_t = 32'h0001_0000; i_det_u = 32'h0000_4000; i_det_v = 32'h0000_4000;
    i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (70) @(negedge clk);
    i_rstn = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_t !== 0 || o_u !== 0 || o_v !== 0 || o_hit !== 1'b0)
      $display("FAIL reset_mid_div: got vld=%b rdy=%b t=%h u=%h v=%h hit=%b want 0 1 0 0 0 0",
               o_valid, o_ready, o_t, o_u, o_v, o_hit);
    else passes++;
    @(negedge clk);
    i_rstn = 1'b1;
    repeat (150) @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1)
      $display("FAIL reset_abort: got vld=%b rdy=%b want 0 1", o_valid, o_ready);
    else passes++;
    send_wait(32'hFFFE_0000, 32'hFFFF_0000, 32'h0000_0000, 32'hFFFF_8000, lat);
    model(32'hFFFE_0000, 32'hFFFF_0000, 32'h0000_0000, 32'hFFFF_8000, elat, et, eu, ev, eh);
    checks++;
    if (lat !== elat || o_t !== et || o_u !== eu || o_v !== ev || o_hit !== eh)
      $display("FAIL recover: got lat=%0d t=%h u=%h v=%h hit=%b want %0d %h %h %h %b",
               lat, o_t, o_u, o_v, o_hit, elat, et, eu, ev, eh);
    else passes++;
    handoff();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, dt, du, dv, et, eu, ev, ad;
    int          lat, elat;
    logic        eh;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: begin d = $urandom; dt = $urandom; du = $urandom; dv = $urandom; end
        1: begin
          ad = $urandom_range(32'h100, 32'h40000);
          du = $urandom_range(0, ad / 2);
          dv = $urandom_range(0, ad / 2);
          dt = $urandom_range(0, ad * 4);
          if ($urandom_range(0, 1) == 1) begin d = -ad; du = -du; dv = -dv; dt = -dt; end
          else d = ad;
        end
        2: begin d = $urandom_range(0, 48) - 24; dt = $urandom; du = $urandom_range(0, 32'hFFFF); dv = 0; end
        default: begin d = $urandom_range(17, 32'h1000); dt = 32'h8000_0000; du = 32'h7FFF_FFFF; dv = $urandom; end
      endcase
      send_wait(d, dt, du, dv, lat);
      model(d, dt, du, dv, elat, et, eu, ev, eh);
      checks++;
      if (lat !== elat) $display("FAIL rand[%0d] latency: got %0d want %0d", i, lat, elat);
      else passes++;
      checks++;
      if (o_t !== et || o_u !== eu || o_v !== ev || o_hit !== eh)
        $display("FAIL rand[%0d] det=%h: got t=%h u=%h v=%h hit=%b want %h %h %h %b",
                 i, d, o_t, o_u, o_v, o_hit, et, eu, ev, eh);
      else passes++;
      handoff();
      checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1)
        $display("FAIL rand[%0d] handoff: got vld=%b rdy=%b want 0 1", i, o_valid, o_ready);
      else passes++;
    end
  endtask

  initial begin
    i_rstn = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_det = '0; i_det_t = '0; i_det_u = '0; i_det_v = '0;
    repeat (3) @(negedge clk);
    test_reset();
    i_rstn = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid_div();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
